byte_decode_ctrl: RTL and testbench
===================================

BYTE_DECODE_CTRL -- requirements
Module: byte_decode_ctrl

Interface
REQ-001 Parameter N_COEFFS, 256, coefficients per polynomial.
REQ-002 Parameter KYBER_Q, 3329, modulus for d=12 reduction.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to decode one polynomial.
REQ-006 d_sel  in  3  width code: 0->d=1, 1->d=4, 2->d=10, 3->d=11, 4->d=12; 5-7 invalid.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse after last coefficient handshake.
REQ-009 err  out  1  one-cycle pulse on start with invalid d_sel.
REQ-010 byte_rd_en  out  1  byte-buffer read strobe.
REQ-011 byte_addr  out  9  byte index, 0..32*d-1.
REQ-012 byte_rdata  in  8  read data, valid exactly one cycle after byte_rd_en.
REQ-013 coeff_valid  out  1  coefficient output valid.
REQ-014 coeff_ready  in  1  sink accepts coefficient.
REQ-015 coeff_idx  out  8  coefficient index 0..255.
REQ-016 coeff_data  out  12  decoded coefficient, zero-extended.

Function
REQ-017 FSM states IDLE, FETCH, WAIT_DATA, EMIT, FINISH; IDLE->FETCH on start with valid d_sel.
REQ-018 Start while busy is ignored; d_sel sampled only on accepted start and held internally.
REQ-019 Invalid d_sel in IDLE: err pulses next cycle, no reads, state stays IDLE, busy stays low.
REQ-020 Bitstream LSB-first: bit j of coefficient i = bit ((i*d+j) mod 8) of byte floor((i*d+j)/8).
REQ-021 Bit accumulator 24 bits wide with 5-bit fill count; new byte appended above current fill.
REQ-022 FETCH: if fill < d and bytes remain, assert byte_rd_en for one cycle, go WAIT_DATA; byte_addr increments per read.
REQ-023 WAIT_DATA: capture byte_rdata, fill += 8, go FETCH if fill still < d, else EMIT.
REQ-024 EMIT: coeff_valid high, coeff_data = low d bits; on valid&&ready shift accumulator right by d, fill -= d, coeff_idx++.
REQ-025 After handshake: EMIT again if fill >= d, else FETCH; after coefficient 255 go FINISH.
REQ-026 At most one read outstanding; exactly 32*d reads per polynomial, never beyond.
REQ-027 coeff_ready low: coeff_valid, coeff_data, coeff_idx held stable until handshake.
REQ-028 d=12: output value minus KYBER_Q if value >= KYBER_Q (single conditional subtract); other d unreduced.
REQ-029 FINISH: done pulses one cycle, busy drops same cycle, next state IDLE; leftover fill is zero.
REQ-030 start in the FINISH cycle ignored; accepted from IDLE the following cycle.

Reset
REQ-031 rst asserted at any time, including mid-decode: state IDLE, accumulator, fill, counters cleared.
REQ-032 Reset output values: busy=0, done=0, err=0, byte_rd_en=0, byte_addr=0, coeff_valid=0, coeff_idx=0, coeff_data=0.
REQ-033 First start accepted on first rising edge after rst deasserts.

Structure
REQ-034 Shared package holds N_COEFFS, KYBER_Q, d_sel enum, d-lookup function, byte-count function (32*d).
REQ-035 One sub-module bit_unpacker: accumulator, fill count, append/shift/extract by d; FSM and counters in top.

Verification
REQ-036 d=1, bytes 0xA5 then zeros -> coeff 0..7 = 1,0,1,0,0,1,0,1; 32 reads; done once.
REQ-037 d=4, byte0=0x3C -> coeff0=12, coeff1=3; 128 reads total.
REQ-038 d=12, bytes 0xFF,0xFF,0xFF -> coeff0=766, coeff1=766; bytes 0x01,0x0D,0x00 -> coeff0=3329->0.
REQ-039 d=10, bytes 0x01,0x04,0x00 -> coeff0=1, coeff1=1; coeff_ready toggled randomly, outputs stable while stalled, 256 coefficients in order.
REQ-040 start with d_sel=6 -> err one pulse, no byte_rd_en, busy low.
REQ-041 rst asserted after coeff 100 -> all outputs reset values; new start d=11 completes with 352 reads, correct data.

Source files
------------

// File: rtl/byte_decode_ctrl_pkg.sv
// Shared constants, types and width helpers for the polynomial byte decoder.
package byte_decode_ctrl_pkg;

  localparam int unsigned N_COEFFS = 256;
  localparam int unsigned KYBER_Q  = 3329;

  typedef enum logic [2:0] {
    DSel1  = 3'd0,
    DSel4  = 3'd1,
    DSel10 = 3'd2,
    DSel11 = 3'd3,
    DSel12 = 3'd4
  } d_sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitData,
    StEmit,
    StFinish
  } state_e;

  // Returns 0 for the unused codes so callers can test validity directly.
  function automatic logic [3:0] d_lookup(logic [2:0] sel);
    logic [3:0] d;
    case (sel)
      DSel1:   d = 4'd1;
      DSel4:   d = 4'd4;
      DSel10:  d = 4'd10;
      DSel11:  d = 4'd11;
      DSel12:  d = 4'd12;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  function automatic logic [8:0] byte_count(logic [3:0] d);
    return {d, 5'd0};
  endfunction

endpackage

// File: rtl/byte_decode_ctrl_if.sv
// Control, byte-buffer read and coefficient stream signals of the decoder.
interface byte_decode_ctrl_if;
  logic        start;
  logic [2:0]  d_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic        byte_rd_en;
  logic [8:0]  byte_addr;
  logic [7:0]  byte_rdata;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [7:0]  coeff_idx;
  logic [11:0] coeff_data;

  modport slave (
    input  start, d_sel, byte_rdata, coeff_ready,
    output busy, done, err, byte_rd_en, byte_addr, coeff_valid, coeff_idx, coeff_data
  );

  modport master (
    output start, d_sel, byte_rdata, coeff_ready,
    input  busy, done, err, byte_rd_en, byte_addr, coeff_valid, coeff_idx, coeff_data
  );
endinterface

// File: rtl/byte_decode_ctrl_bit_unpacker.sv
// LSB-first bit accumulator: bytes are appended above the current fill and
// coefficients of width d are taken from the bottom.
module bit_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        append,
  input  logic [7:0]  din,
  input  logic        shift,
  input  logic [3:0]  d,
  output logic [4:0]  fill,
  output logic [11:0] dout
);

  logic [23:0] acc_q, acc_d;
  logic [4:0]  fill_q, fill_d;
  logic [11:0] mask;

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (append) begin
      acc_d  = acc_q | (24'(din) << fill_q);
      fill_d = fill_q + 5'd8;
    end else if (shift) begin
      acc_d  = acc_q >> d;
      fill_d = fill_q - 5'(d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  always_comb begin
    mask = ~(12'hfff << d);
    dout = acc_q[11:0] & mask;
    fill = fill_q;
  end

endmodule

// File: rtl/byte_decode_ctrl.sv
// Decodes one packed polynomial of 256 d-bit coefficients from a byte buffer
// into a ready/valid coefficient stream.
module byte_decode_ctrl #(
  parameter int unsigned N_COEFFS = byte_decode_ctrl_pkg::N_COEFFS,
  parameter int unsigned KYBER_Q  = byte_decode_ctrl_pkg::KYBER_Q
) (
  input logic             clk,
  input logic             rst,
  byte_decode_ctrl_if.slave bus
);

  import byte_decode_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  d_q;
  logic [8:0]  rd_cnt_q;
  logic [7:0]  idx_q;
  logic        err_q;

  logic [3:0]  d_new;
  logic        accept, bytes_left, fill_lt_d, hs, last;
  logic        rd_en, unp_clr, unp_append;
  logic [4:0]  fill;
  logic [11:0] raw, reduced;

  always_comb begin
    d_new      = d_lookup(bus.d_sel);
    accept     = (state_q == StIdle) && bus.start && (d_new != 4'd0);
    bytes_left = rd_cnt_q < byte_count(d_q);
    fill_lt_d  = fill < {1'b0, d_q};
    hs         = (state_q == StEmit) && bus.coeff_ready;
    last       = idx_q == 8'(N_COEFFS - 1);
    reduced    = ((d_q == 4'd12) && (raw >= 12'(KYBER_Q))) ? raw - 12'(KYBER_Q) : raw;
  end

  bit_unpacker u_unpacker (
    .clk    (clk),
    .rst    (rst),
    .clr    (unp_clr),
    .append (unp_append),
    .din    (bus.byte_rdata),
    .shift  (hs),
    .d      (d_q),
    .fill   (fill),
    .dout   (raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (accept) state_d = StFetch;
      StFetch: begin
        if (!fill_lt_d)     state_d = StEmit;
        else if (bytes_left) state_d = StWaitData;
        else                 state_d = StFinish;
      end
      StWaitData: state_d = ((fill + 5'd8) < {1'b0, d_q}) ? StFetch : StEmit;
      StEmit: begin
        if (hs) begin
          if (last)                                state_d = StFinish;
          else if ((fill - 5'(d_q)) >= {1'b0, d_q}) state_d = StEmit;
          else                                     state_d = StFetch;
        end
      end
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en           = (state_q == StFetch) && fill_lt_d && bytes_left;
    unp_clr         = accept;
    unp_append      = state_q == StWaitData;
    bus.byte_rd_en  = rd_en;
    bus.byte_addr   = rd_cnt_q;
    bus.busy        = (state_q == StFetch) || (state_q == StWaitData) || (state_q == StEmit);
    bus.done        = state_q == StFinish;
    bus.err         = err_q;
    bus.coeff_valid = state_q == StEmit;
    bus.coeff_idx   = idx_q;
    bus.coeff_data  = (state_q == StEmit) ? reduced : 12'd0;
  end

  // d is latched on acceptance so d_sel may change freely during a decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q      <= '0;
      rd_cnt_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_q == StIdle) && bus.start && (d_new == 4'd0);
      if (accept) begin
        d_q      <= d_new;
        rd_cnt_q <= '0;
        idx_q    <= '0;
      end else begin
        if (rd_en)                 rd_cnt_q <= rd_cnt_q + 9'd1;
        if (state_q == StFinish)   rd_cnt_q <= '0;
        if (hs)                    idx_q    <= idx_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_decode_ctrl.sv
// Randomized scoreboard bench for byte_decode_ctrl with a bit-level reference model.
module tb_byte_decode_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_decode_ctrl_if bus ();

  byte_decode_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mem[384];
  int         checks = 0;
  int         errors = 0;
  int         tb_rd_cnt, done_cnt, err_cnt, hs_cnt, busy_cnt;
  bit         prev_rd;
  int         dtab[5] = '{1, 4, 10, 11, 12};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Coefficient i is bits i*d .. i*d+d-1 of the little-endian bitstream.
  function automatic int ref_coeff(int d, int i);
    int v = 0;
    for (int j = 0; j < d; j++) begin
      int b = i * d + j;
      if (mem[b / 8][b % 8]) v += (1 << j);
    end
    if (d == 12 && v >= 3329) v -= 3329;
    return v;
  endfunction

  task automatic clear_stats();
    tb_rd_cnt = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    hs_cnt    = 0;
    busy_cnt  = 0;
    expq.delete();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 384; i++) mem[i] = 8'($urandom);
  endtask

  task automatic prep(int d);
    exp_t e;
    clear_stats();
    for (int i = 0; i < 256; i++) begin
      e.idx  = i;
      e.data = ref_coeff(d, i);
      expq.push_back(e);
    end
  endtask

  task automatic start_now(logic [2:0] sel);
    bus.start = 1'b1;
    bus.d_sel = sel;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.d_sel = 3'($urandom);
  endtask

  task automatic launch(logic [2:0] sel);
    @(posedge clk);
    #1;
    start_now(sel);
  endtask

  task automatic finish_poly(string name, int d);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 20000), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_reads"}, tb_rd_cnt, 32 * d);
    chk({name, "_coeffs"}, hs_cnt, 256);
    chk({name, "_left_in_queue"}, expq.size(), 0);
    chk({name, "_busy_after"}, bus.busy, 0);
  endtask

  task automatic check_reset(string name);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_done"}, bus.done, 0);
    chk({name, "_err"}, bus.err, 0);
    chk({name, "_rd_en"}, bus.byte_rd_en, 0);
    chk({name, "_addr"}, bus.byte_addr, 0);
    chk({name, "_valid"}, bus.coeff_valid, 0);
    chk({name, "_idx"}, bus.coeff_idx, 0);
    chk({name, "_data"}, bus.coeff_data, 0);
  endtask

  // Byte-buffer responder plus output monitor, both on the falling edge.
  initial begin
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.byte_rd_en) begin
          chk("rd_addr", bus.byte_addr, tb_rd_cnt);
          chk("rd_outstanding", prev_rd, 0);
          bus.byte_rdata = mem[bus.byte_addr];
          tb_rd_cnt++;
        end
        prev_rd = bus.byte_rd_en;
        if (bus.coeff_valid) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL coeff_extra: got idx %0d data %0d expected none", bus.coeff_idx,
                     bus.coeff_data);
          end else begin
            chk("coeff_idx", bus.coeff_idx, expq[0].idx);
            chk("coeff_data", bus.coeff_data, expq[0].data);
            if (bus.coeff_ready) begin
              void'(expq.pop_front());
              hs_cnt++;
            end
          end
        end
        if (bus.done) done_cnt++;
        if (bus.err)  err_cnt++;
        if (bus.busy) busy_cnt++;
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  initial begin
    bus.coeff_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.coeff_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.d_sel      = 3'd0;
    bus.byte_rdata = 8'd0;
    clear_stats();
    repeat (2) @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // d=1: 0xA5 then zeros
    for (int i = 0; i < 384; i++) mem[i] = 8'd0;
    mem[0] = 8'ha5;
    prep(1);
    launch(3'd0);
    finish_poly("d1", 1);

    // d=4 with a start issued mid-decode that must be ignored
    rand_mem();
    mem[0] = 8'h3c;
    prep(4);
    launch(3'd0 + 3'd1);
    repeat (20) @(posedge clk);
    #1;
    start_now(3'd4);
    finish_poly("d4", 4);

    // d=12 reduction corners
    rand_mem();
    mem[0] = 8'hff; mem[1] = 8'hff; mem[2] = 8'hff;
    prep(12);
    launch(3'd4);
    finish_poly("d12_max", 12);
    rand_mem();
    mem[0] = 8'h01; mem[1] = 8'h0d; mem[2] = 8'h00;
    prep(12);
    launch(3'd4);
    finish_poly("d12_q", 12);

    // d=10
    rand_mem();
    mem[0] = 8'h01; mem[1] = 8'h04; mem[2] = 8'h00;
    prep(10);
    launch(3'd2);
    finish_poly("d10", 10);

    // invalid width code
    clear_stats();
    launch(3'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("inv_err_pulses", err_cnt, 1);
    chk("inv_reads", tb_rd_cnt, 0);
    chk("inv_busy_cycles", busy_cnt, 0);

    // d=11 aborted by reset after coefficient 100, then a fresh decode
    rand_mem();
    prep(11);
    launch(3'd3);
    n = 0;
    while (hs_cnt < 101 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("abort_timeout", 32'(n < 20000), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    rand_mem();
    prep(11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_now(3'd3);
    finish_poly("d11", 11);

    // random widths
    for (int k = 0; k < 3; k++) begin
      int sel = $urandom_range(0, 4);
      rand_mem();
      prep(dtab[sel]);
      launch(3'(sel));
      finish_poly("rand", dtab[sel]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
